// File: rtl/alu_writeback_if.sv
// alu_writeback_if: op/flag input handshake and retirement-record output handshake for alu_writeback.
interface alu_writeback_if #(parameter int WIDTH = 11);
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              op;
  logic [1:0]              cond;
  logic [1:0]              test_kind;
  logic signed [WIDTH-1:0] alu_out;
  logic                    alu_overflow;
  logic                    gr_flag;
  logic                    le_flag;
  logic                    eq_flag;
  logic                    out_valid;
  logic                    out_ready;
  logic                    skipped;
  logic                    sat;
  modport master (
    output in_valid, op, cond, test_kind, alu_out, alu_overflow, gr_flag, le_flag, eq_flag, out_ready,
    input  in_ready, out_valid, skipped, sat
  );
  modport slave (
    input  in_valid, op, cond, test_kind, alu_out, alu_overflow, gr_flag, le_flag, eq_flag, out_ready,
    output in_ready, out_valid, skipped, sat
  );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: clamps ALU results into acc/dat, tracks +/- condition state, retires through a one-deep output register.
module alu_writeback #(
  parameter int WIDTH  = 11,
  parameter int MAXVAL = 999
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_writeback_if.slave          bus,
  output logic signed [WIDTH-1:0] acc,
  output logic signed [WIDTH-1:0] dat,
  output logic [1:0]              cond_state,
  output logic [15:0]             retired
);
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] PLUS  = 2'd1;
  localparam logic [1:0] MINUS = 2'd2;
  localparam logic signed [WIDTH-1:0] POS = WIDTH'(MAXVAL);
  localparam logic signed [WIDTH-1:0] NEG = -POS;
  logic                    accept;
  logic                    exec;
  logic                    hi;
  logic                    lo;
  logic                    clamped;
  logic                    is_wr;
  logic                    counted;
  logic                    any_flag;
  logic signed [WIDTH-1:0] res;
  logic [1:0]              test_cs;
  assign bus.in_ready = !reset && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    exec = bus.cond == 2'd0 || (bus.cond == 2'd1 && cond_state == PLUS)
        || (bus.cond == 2'd2 && cond_state == MINUS);
    hi = bus.alu_out > POS;
    lo = bus.alu_out < NEG;
    clamped = bus.alu_overflow || hi || lo;
    // an overflowed result carries the inverted sign, so saturate towards the opposite of its msb
    res = bus.alu_overflow ? (bus.alu_out[WIDTH-1] ? POS : NEG) : hi ? POS : lo ? NEG : bus.alu_out;
    is_wr = bus.op == 3'd1 || bus.op == 3'd2;
    counted = bus.op >= 3'd1 && bus.op <= 3'd4;
    any_flag = bus.gr_flag || bus.le_flag || bus.eq_flag;
    test_cs = bus.test_kind == 2'd0 ? (bus.eq_flag ? PLUS : MINUS)
            : bus.test_kind == 2'd1 ? (bus.gr_flag ? PLUS : MINUS)
            : bus.test_kind == 2'd2 ? (bus.le_flag ? PLUS : MINUS)
            : bus.gr_flag ? PLUS : bus.le_flag ? MINUS : NONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      dat <= '0;
      cond_state <= NONE;
      retired <= '0;
      bus.out_valid <= 1'b0;
      bus.skipped <= 1'b0;
      bus.sat <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.skipped <= !exec;
      bus.sat <= exec && is_wr && clamped;
      if (exec) begin
        if (bus.op == 3'd1) acc <= res;
        if (bus.op == 3'd2) dat <= res;
        if (bus.op == 3'd3 && any_flag) cond_state <= test_cs;
        if (bus.op == 3'd4) cond_state <= NONE;
        if (counted) retired <= retired + 16'd1;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and random ops checked against an integer reference model of alu_writeback.
module tb_alu_writeback;
  localparam int W = 11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] dat;
  logic [1:0] cond_state;
  logic [15:0] retired;
  int checks = 0;
  int passed = 0;
  int m_acc = 0;
  int m_dat = 0;
  int m_cs = 0;
  int m_ret = 0;
  bit m_ov = 0;
  bit m_skip = 0;
  bit m_sat = 0;
  always #5 clk = ~clk;
  alu_writeback_if #(.WIDTH(W)) bus ();
  alu_writeback #(.WIDTH(W), .MAXVAL(999)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .acc(acc), .dat(dat), .cond_state(cond_state), .retired(retired)
  );
  task automatic wb_check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic cyc(input int o, input int c, input int k, input int v, input bit ovf,
                     input bit g, input bit l, input bit e, input bit iv, input bit ordy,
                     input bit rst = 1'b0);
    bit ex;
    bit s;
    int r;
    @(negedge clk);
    reset = rst;
    bus.in_valid = iv;
    bus.op = 3'(o);
    bus.cond = 2'(c);
    bus.test_kind = 2'(k);
    bus.alu_out = W'(v);
    bus.alu_overflow = ovf;
    bus.gr_flag = g;
    bus.le_flag = l;
    bus.eq_flag = e;
    bus.out_ready = ordy;
    #1;
    wb_check("in_ready", int'(bus.in_ready), int'(!rst && (!m_ov || ordy)));
    if (rst) begin
      m_acc = 0; m_dat = 0; m_cs = 0; m_ret = 0; m_ov = 0; m_skip = 0; m_sat = 0;
    end else if (iv && (!m_ov || ordy)) begin
      ex = c == 0 || (c == 1 && m_cs == 1) || (c == 2 && m_cs == 2);
      m_ov = 1; m_skip = !ex; m_sat = 0;
      if (ex) begin
        r = ovf ? (v < 0 ? 999 : -999) : v > 999 ? 999 : v < -999 ? -999 : v;
        s = ovf || v > 999 || v < -999;
        if (o == 1) begin m_acc = r; m_sat = s; end
        if (o == 2) begin m_dat = r; m_sat = s; end
        if (o == 3 && (g || l || e)) begin
          if (k == 0) m_cs = e ? 1 : 2;
          else if (k == 1) m_cs = g ? 1 : 2;
          else if (k == 2) m_cs = l ? 1 : 2;
          else m_cs = g ? 1 : l ? 2 : 0;
        end
        if (o == 4) m_cs = 0;
        if (o >= 1 && o <= 4) m_ret = (m_ret + 1) % 65536;
      end
    end else if (ordy) m_ov = 0;
    @(posedge clk);
    #1;
    wb_check("acc", int'(acc), m_acc);
    wb_check("dat", int'(dat), m_dat);
    wb_check("cond_state", int'(cond_state), m_cs);
    wb_check("retired", int'(retired), m_ret);
    wb_check("out_valid", int'(bus.out_valid), int'(m_ov));
    wb_check("skipped", int'(bus.skipped), int'(m_skip));
    wb_check("sat", int'(bus.sat), int'(m_sat));
  endtask
  initial begin
    int f;
    cyc(1, 0, 0, 500, 0, 0, 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 500, 0, 0, 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 500, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1020, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, -1000, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, -1024, 1, 0, 0, 0, 1, 1);
    cyc(3, 0, 3, 0, 0, 0, 1, 0, 1, 1);
    cyc(2, 1, 0, 7, 0, 0, 0, 0, 1, 1);
    cyc(2, 2, 0, 7, 0, 0, 0, 0, 1, 1);
    cyc(3, 0, 3, 0, 0, 0, 0, 1, 1, 1);
    cyc(2, 1, 0, 9, 0, 0, 0, 0, 1, 1);
    cyc(2, 2, 0, 9, 0, 0, 0, 0, 1, 1);
    cyc(3, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc(4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(3, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc(3, 3, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc(2, 0, 0, -1023, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 42, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 42, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      f = int'($urandom_range(0, 7));
      cyc(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 2047)) - 1024, 1'($urandom_range(0, 3) == 0),
          f[0], f[1], f[2], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 99) == 0));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    while (m_ret != 65535) cyc(4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    wb_check("wrap", int'(retired), 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    wb_check("nop_count", int'(retired), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback and condition stage that sits directly downstream of `alu`. It accepts one ALU result per handshake together with the overflow and compare flags. It clamps the result to the game's ±999 range and writes it into the `acc` or `dat` register, or updates the +/- condition state used by conditionally prefixed instructions. Each result then retires through a one-deep output register with valid/ready backpressure.

## Interface
Parameters:
- `WIDTH`, default 11: datapath width; must match `alu`.
- `MAXVAL`, default 999: saturation magnitude.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: an op is presented.
- `in_ready` output 1: stage can accept an op.
- `op` input 3: 0 NOP, 1 WR_ACC, 2 WR_DAT, 3 TEST, 4 CLR_COND, 5-7 reserved.
- `cond` input 2: 0 ALWAYS, 1 PLUS, 2 MINUS, 3 reserved.
- `test_kind` input 2: 0 TEQ, 1 TGT, 2 TLT, 3 TCP.
- `alu_out` input WIDTH: signed ALU result.
- `alu_overflow` input 1: ALU overflow.
- `gr_flag` input 1: ALU compare flag, in0 > in1.
- `le_flag` input 1: ALU compare flag, in0 < in1.
- `eq_flag` input 1: ALU compare flag, in0 == in1.
- `acc` output WIDTH: signed accumulator.
- `dat` output WIDTH: signed data register.
- `cond_state` output 2: 0 NONE, 1 PLUS, 2 MINUS.
- `out_valid` output 1: a retirement record is held.
- `out_ready` input 1: consumer takes the record.
- `skipped` output 1: the held op was suppressed by its condition.
- `sat` output 1: the held op clamped its result.
- `retired` output 16: count of executed, non-skipped ops.

## Operation
**Accept.** An op is accepted on a rising edge where `in_valid && in_ready`. `in_ready` is defined as `!reset && (!out_valid || out_ready)`.

**Condition check.** An op executes when any of the following holds:
- `cond` is ALWAYS;
- `cond` is PLUS and `cond_state` is PLUS;
- `cond` is MINUS and `cond_state` is MINUS.

Otherwise the op is skipped. A skipped op changes no register except the output record and `skipped`, which is set to 1. Reserved `cond` = 3 is always skipped.

**Clamp.** Let v = `alu_out`.
- If `alu_overflow` is set, the result is +MAXVAL when v[WIDTH-1] = 1 and -MAXVAL otherwise. The wrapped sign is the inverse of the true sign.
- Else if v > MAXVAL, the result is MAXVAL.
- Else if v < -MAXVAL, the result is -MAXVAL.
- Else the result is v.
- `sat` = 1 if either clamp branch was taken. `sat` is only meaningful for WR_ACC and WR_DAT; it is 0 for all other ops.

**Ops.**
- WR_ACC: `acc` <= clamped result.
- WR_DAT: `dat` <= clamped result.
- TEST: `cond_state` is updated from the flags as follows:
  - TEQ: eq → PLUS, else MINUS.
  - TGT: gr → PLUS, else MINUS.
  - TLT: le → PLUS, else MINUS.
  - TCP: gr → PLUS, le → MINUS, eq → NONE.
  - No flag set is illegal. In that case `cond_state` holds, and the op still retires.
- CLR_COND: `cond_state` <= NONE.
- NOP and reserved ops 5-7 change no architectural state. They retire but are not counted.
- TEST may itself be conditional. The condition is evaluated against `cond_state` before the update.

**Counter.** `retired` increments by 1 for each executed WR_ACC, WR_DAT, TEST or CLR_COND. It wraps from 0xFFFF to 0.

**Output register states.**
- EMPTY (`out_valid` = 0) → FULL on accept.
- FULL → EMPTY on `out_ready` with no new accept.
- FULL → FULL on `out_ready` with a simultaneous accept; the new record replaces the old.
- FULL with `!out_ready` holds the record unchanged and deasserts `in_ready`.

## Timing
- **Reset values:** `acc` = 0, `dat` = 0, `cond_state` = NONE, `out_valid` = 0, `skipped` = 0, `sat` = 0, `retired` = 0. `in_ready` = 0 while `reset` is high.
- **Reset mid-operation:** a held record is dropped, and an op presented in the reset cycle is not accepted.
- **Latency:** 1 cycle. All effects of an op accepted at edge N (`acc`/`dat`/`cond_state`/`retired`, `out_valid`, `skipped`, `sat`) are visible after edge N.
- **Back-to-back ops:** one op per cycle when `out_ready` is held at 1. An op sees the `cond_state` written by the op accepted one edge earlier.
- **Input sampling:** `alu_out` and all flags are sampled only on the accept edge. `alu` is combinational, so its operands must be stable through that edge.
- **Held record:** `skipped` and `sat` stay stable while `out_valid && !out_ready`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `in_valid` = 1 → all outputs hold their reset values, nothing is accepted, `in_ready` = 0.
- **Write and clamp:**
  - WR_ACC, ALWAYS, `alu_out` = 500 → `acc` = 500, `sat` = 0.
  - `alu_out` = 1020 → `acc` = 999, `sat` = 1.
  - `alu_out` = -1000 → `acc` = -999.
  - `alu_overflow` = 1 with `alu_out` = 11'h400 → `acc` = +999.
- **Conditional execution:** TCP with `le_flag` → `cond_state` = MINUS. Then PLUS WR_DAT 7 → `skipped` = 1, `dat` unchanged, `retired` unchanged. Then MINUS WR_DAT 7 → `dat` = 7.
- **TCP equal:** `eq_flag` → `cond_state` = NONE; both PLUS and MINUS ops are then skipped. CLR_COND after TEQ sets NONE.
- **Backpressure:** hold `out_ready` = 0 for 3 cycles after one accept → `in_ready` = 0 and the record is stable. Release with `in_valid` = 1 → the next op is accepted in the same cycle.
- **Counter wrap:** preload via 65535 executed ops, then one more → `retired` = 0. 10 NOPs → `retired` unchanged.
